instr_encoder_loader: RTL and testbench

Boot-time writer for instruction memory; the encode-side counterpart of the control unit's opcode/funct decode.
- Accepts decoded instruction descriptors over a valid/ready stream and packs each into an RV32I 32-bit word.
- Writes the words sequentially into instruction memory through a stalling write port.
- Holds the core in reset (cpu_run=0) until loading completes.

---
 rtl/rv_isa_pkg.sv | 42 ++++
 rtl/rv_instr_pack.sv | 79 +++++++
 rtl/instr_encoder_loader.sv | 119 +++++++++++
 tb/tb_instr_encoder_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rv_isa_pkg                                         |
// | Description : RV32I opcode constants, instruction-class and      |
// |               loader-state encodings shared by the loader and    |
// |               the control unit.                                  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_IALU   = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } instr_class_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } ldr_state_e;

endpackage
`default_nettype wire

// File: rtl/rv_instr_pack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rv_instr_pack                                      |
// | Description : Combinational packer from a decoded descriptor to  |
// |               an RV32I word, with class-invalid and immediate    |
// |               range flags. Range checking exists only when       |
// |               IMM_CHECK_EN is defined; otherwise surplus         |
// |               immediate bits are silently dropped.               |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module rv_instr_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        class_bad,
  output logic        imm_bad
);

  logic        is_shift;
  logic [11:0] ialu_imm;

  // Shift immediates carry funct7 in the upper immediate bits
  always_comb begin
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    ialu_imm = is_shift ? {1'b0, f7b5, 5'b00000, imm[4:0]} : imm[11:0];
  end

  // Field placement for each instruction class
  always_comb begin
    word      = '0;
    class_bad = 1'b0;
    case (cls)
      CLS_R:      word = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      CLS_IALU:   word = {ialu_imm, rs1, funct3, rd, OP_IMM};
      CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      CLS_LUI:    word = {imm[31:12], rd, OP_LUI};
      CLS_AUIPC:  word = {imm[31:12], rd, OP_AUIPC};
      default:    class_bad = 1'b1;
    endcase
  end

`ifdef IMM_CHECK_EN
  logic fits12, fits13, fits21;

  // Immediate must survive truncation to the class's field width
  always_comb begin
    fits12  = (&imm[31:11]) | ~(|imm[31:11]);
    fits13  = (&imm[31:12]) | ~(|imm[31:12]);
    fits21  = (&imm[31:20]) | ~(|imm[31:20]);
    imm_bad = 1'b0;
    case (cls)
      CLS_IALU:   imm_bad = is_shift ? (|imm[31:5]) : ~fits12;
      CLS_LOAD,
      CLS_JALR,
      CLS_STORE:  imm_bad = ~fits12;
      CLS_BRANCH: imm_bad = ~fits13 | imm[0];
      CLS_JAL:    imm_bad = ~fits21 | imm[0];
      CLS_LUI,
      CLS_AUIPC:  imm_bad = |imm[11:0];
      default:    imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : instr_encoder_loader                               |
// | Description : Boot-time instruction-memory writer. Packs decoded |
// |               descriptors into RV32I words, writes them to       |
// |               consecutive word addresses and releases the core   |
// |               once the last word lands. Optional immediate range |
// |               checking is enabled by defining IMM_CHECK_EN.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  ldr_state_e  state;
  logic        last_q;
  logic [31:0] packed_word;
  logic        class_bad;
  logic        imm_bad;

  rv_instr_pack u_pack (
    .cls       (in_class),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .f7b5      (in_f7b5),
    .imm       (in_imm),
    .word      (packed_word),
    .class_bad (class_bad),
    .imm_bad   (imm_bad)
  );

  // Status and handshake outputs decode directly from the registered state
  always_comb begin
    in_ready = (state == ST_LOAD);
    imem_we  = (state == ST_WRITE);
    busy     = (state == ST_LOAD) || (state == ST_WRITE);
    cpu_run  = (state == ST_DONE);
    err      = (state == ST_ERR);
  end

  // Load sequencer: accept, hold the write until memory takes it, advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_q     <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_LOAD;
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (class_bad || imm_bad) begin
              state <= ST_ERR;
            end else begin
              imem_wdata <= packed_word;
              last_q     <= in_last;
              state      <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (imem_ready) begin
            word_count <= word_count + CNT_ONE;
            if (last_q) begin
              state <= ST_DONE;
            end else if (&imem_addr) begin
              // No room for another word; refuse to wrap over earlier code
              state <= ST_ERR;
            end else begin
              imem_addr <= imem_addr + ADDR_ONE;
              state     <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_instr_encoder_loader                            |
// | Description : Self-checking bench for instr_encoder_loader with  |
// |               directed vectors and randomized sessions against   |
// |               an arithmetic reference encoder. Honors            |
// |               IMM_CHECK_EN.                                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_instr_encoder_loader;

  localparam int AW   = 4;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_class = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic          in_f7b5 = 1'b0;
  logic [31:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic          imem_ready = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run, busy, err;
  logic [AW:0]   word_count;

  int errors = 0;
  int checks = 0;

  // reference-model session state
  int m_addr, m_count;
  bit m_done, m_err;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoder built from field values and shifts
  function automatic logic [31:0] ref_encode(int cls, int rd, int rs1, int rs2, int f3, int f7b5,
                                             logic [31:0] imm);
    logic [31:0] r, ifld, base;
    r    = 32'(rd) << 7;
    base = (32'(f3) << 12) | (32'(rs1) << 15);
    case (cls)
      0: return (32'(f7b5) << 30) | (32'(rs2) << 20) | base | r | 32'h33;
      1: begin
        ifld = imm & 32'hFFF;
        if (f3 == 1 || f3 == 5) ifld = (32'(f7b5) << 10) | (imm & 32'h1F);
        return (ifld << 20) | base | r | 32'h13;
      end
      2: return ((imm & 32'hFFF) << 20) | base | r | 32'h03;
      6: return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | r | 32'h67;
      3: return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base
                | ((imm & 32'h1F) << 7) | 32'h23;
      4: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                | base | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
      5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | r | 32'h6F;
      7: return (imm & 32'hFFFFF000) | r | 32'h37;
      8: return (imm & 32'hFFFFF000) | r | 32'h17;
      default: return 32'h0;
    endcase
  endfunction

  // Whether the loader should accept this immediate
  function automatic bit ref_imm_ok(int cls, int f3, logic [31:0] imm);
`ifdef IMM_CHECK_EN
    int s;
    s = $signed(imm);
    case (cls)
      1: if (f3 == 1 || f3 == 5) return imm < 32; else return s >= -2048 && s <= 2047;
      2, 3, 6: return s >= -2048 && s <= 2047;
      4: return s >= -4096 && s <= 4095 && (s % 2 == 0);
      5: return s >= -1048576 && s <= 1048575 && (s % 2 == 0);
      7, 8: return (imm % 4096) == 0;
      default: return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] rand_imm(int cls, int f3);
    if ($urandom_range(0, 3) == 0) return $urandom;
    case (cls)
      1: if (f3 == 1 || f3 == 5) return 32'($urandom_range(0, 31));
         else return 32'($signed($urandom_range(0, 4095)) - 2048);
      2, 3, 6: return 32'($signed($urandom_range(0, 4095)) - 2048);
      4: return 32'($signed($urandom_range(0, 8191)) - 4096) & ~32'h1;
      5: return 32'($signed($urandom_range(0, 2097151)) - 1048576) & ~32'h1;
      7, 8: return $urandom & 32'hFFFFF000;
      default: return $urandom;
    endcase
  endfunction

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_addr = BASE; m_count = 0; m_done = 0; m_err = 0;
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
    check("start_err", err, 0);
    check("start_count", word_count, 0);
    check("start_addr", imem_addr, BASE);
  endtask

  // One descriptor: handshake, optional stall, write; fixed_word[32] enables a literal check
  task automatic send(input int cls, input int rd, input int rs1, input int rs2, input int f3,
                      input int f7b5, input logic [31:0] imm, input bit last, input int stall,
                      input logic [32:0] fixed_word);
    int n;
    logic [31:0] w;
    @(negedge clk);
    in_valid = 1'b1; in_class = 4'(cls); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_f7b5 = f7b5[0]; in_imm = imm; in_last = last; imem_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (cls > 8 || !ref_imm_ok(cls, f3, imm)) begin
      m_err = 1;
      check("reject_err", err, 1);
      check("reject_no_we", imem_we, 0);
      check("reject_run", cpu_run, 0);
      return;
    end
    w = ref_encode(cls, rd, rs1, rs2, f3, f7b5, imm);
    check("write_we", imem_we, 1);
    check("write_in_ready", in_ready, 0);
    check("write_addr", imem_addr, m_addr);
    check("write_data", imem_wdata, w);
    if (fixed_word[32]) check("write_vector", imem_wdata, fixed_word[31:0]);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_we", imem_we, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_addr", imem_addr, m_addr);
      check("stall_data", imem_wdata, w);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    m_count++;
    if (last) m_done = 1;
    else if (m_addr == (1 << AW) - 1) m_err = 1;
    else m_addr++;
    check("post_count", word_count, m_count);
    check("post_err", err, m_err);
    check("post_run", cpu_run, m_done);
    check("post_busy", busy, !(m_done || m_err));
  endtask

  initial begin
    int n, cls, f3;
    logic [31:0] imm;

    // reset values
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 0);
    check("rst_run", cpu_run, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_count", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single add
    start_session();
    send(0, 3, 1, 2, 0, 0, 32'h0, 1, 0, {1'b1, 32'h002081B3});
    check("add_run", cpu_run, 1);

    // sub / addi / srai stream
    start_session();
    send(0, 3, 1, 2, 0, 1, 32'h0, 0, 0, {1'b1, 32'h402081B3});
    send(1, 1, 0, 0, 0, 0, 32'd5, 0, 1, {1'b1, 32'h00500093});
    send(1, 1, 1, 0, 5, 1, 32'd3, 1, 0, {1'b1, 32'h4030D093});

    // beq / jal / lui with a three-cycle memory stall on lui
    start_session();
    send(4, 0, 1, 2, 0, 0, 32'd8, 0, 0, {1'b1, 32'h00208463});
    send(5, 1, 0, 0, 0, 0, 32'd16, 0, 0, {1'b1, 32'h010000EF});
    send(7, 5, 0, 0, 0, 0, 32'h12345000, 1, 3, {1'b1, 32'h123452B7});

    // address overflow: every slot filled with none marked last
    start_session();
    for (int k = 0; k < (1 << AW); k++) send(1, k % 32, 0, 0, 0, 0, 32'(k), 0, 0, 33'h0);
    check("ovf_err", err, 1);
    check("ovf_run", cpu_run, 0);
    check("ovf_count", word_count, 1 << AW);
    start_session();
    check("restart_err_clr", err, 0);

    // invalid class
    send(12, 1, 1, 1, 0, 0, 32'h0, 1, 0, 33'h0);

    // oversized addi immediate: rejected with checking, truncated without
    start_session();
`ifdef IMM_CHECK_EN
    send(1, 1, 0, 0, 0, 0, 32'd4096, 1, 0, 33'h0);
`else
    send(1, 1, 0, 0, 0, 0, 32'd4096, 1, 0, {1'b1, 32'h00000093});
`endif

    // asynchronous reset in the middle of a write
    start_session();
    @(negedge clk);
    in_valid = 1'b1; in_class = 4'd0; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst_pre_we", imem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we", imem_we, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_addr", imem_addr, BASE);
    check("midrst_wdata", imem_wdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_session();
    send(2, 7, 3, 0, 2, 0, 32'hFFFFFFFC, 1, 1, 33'h0);

    // randomized sessions
    for (int s = 0; s < 25; s++) begin
      start_session();
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        if (m_err) break;
        cls = ($urandom_range(0, 11) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
        f3  = $urandom_range(0, 7);
        imm = rand_imm(cls, f3);
        send(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), f3,
             $urandom_range(0, 1), imm, k == n - 1, $urandom_range(0, 2), 33'h0);
      end
      check("sess_run", cpu_run, m_done && !m_err);
      check("sess_err", err, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
